parking_slot_counter: RTL and testbench
=======================================

# parking_slot_counter

Tracks free parking spaces from the entry and exit car sensors and drives the 3-bit `binary` input of the free-space 7-segment decoder. It also controls the barrier gate and flags rejected entries. Sensor inputs are asynchronous and bouncy. The block synchronises them, debounces them, edge-detects them and sequences the gate through a small FSM.

## Interface
- `CAPACITY`, 4: total spaces. Legal range 1..7; the default matches the decoder's valid range 0..4.
- `DEBOUNCE`, 2: consecutive synchronised-high samples required before a sensor counts as asserted. Legal range ≥1.
- `GATE_CYCLES`, 5: number of cycles `gate_open` is held per accepted car. Legal range ≥1.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `entry_sensor`  in  1  car present at the entry lane; asynchronous.
- `exit_sensor`  in  1  car present at the exit lane; asynchronous.
- `free_count`  out  3  free spaces, 0..CAPACITY; connects to the decoder's `binary` input.
- `full`  out  1  high when `free_count`==0.
- `gate_open`  out  1  barrier raised.
- `deny`  out  1  one-cycle pulse when an entry is refused because the lot is full.

## Operation
- Reset values:
  - `free_count`=CAPACITY, `full`=0, `gate_open`=0, `deny`=0.
  - FSM in IDLE.
  - Synchronisers, debounce counters and edge registers all cleared.
- Per-sensor front end:
  - 2-flop synchroniser.
  - Saturating debounce counter: increments while the synchronised level is 1, clears to 0 when it is 0.
  - Debounced level is 1 when the counter is ≥DEBOUNCE.
  - Event = debounced level rising, i.e. a 1-cycle pulse.
- FSM states: IDLE, GATE, HOLD.
  - IDLE, entry event, `free_count`>0: decrement `free_count`, go to GATE.
  - IDLE, entry event, `free_count`==0: pulse `deny`, stay in IDLE, count unchanged.
  - IDLE, exit event, `free_count`<CAPACITY: increment `free_count`, go to GATE.
  - IDLE, exit event, `free_count`==CAPACITY: ignore it (spurious exit); no gate, no `deny`.
  - IDLE, entry and exit events in the same cycle:
    - Both legal: count unchanged, go to GATE.
    - Lot full: exit processed first, then entry accepted. Net count unchanged, go to GATE, no `deny`.
  - GATE: `gate_open`=1. A cycle counter runs for GATE_CYCLES cycles, then the FSM goes to HOLD.
  - HOLD: `gate_open`=0. Wait until both debounced levels are 0, then return to IDLE. This prevents one long-standing car from being counted twice.
  - Events arriving in GATE or HOLD are discarded; `deny` is not asserted for them.
- `free_count` never leaves 0..CAPACITY; no wrap in either direction.
- `full` is decoded combinationally from the registered `free_count`.
- Reset mid-operation: all state returns to reset values on the next edge. A gate in progress closes and the count returns to CAPACITY.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples a sensor high.
  - Synchroniser output is high after edge 2.
  - Debounced level rises after edge DEBOUNCE+2.
  - `free_count`, `deny` and the FSM update at edge DEBOUNCE+3.
  - With the default DEBOUNCE=2, the update lands on edge 5.
- `gate_open` rises at the same edge as the count change and stays high for exactly GATE_CYCLES cycles.
- `deny` is high for exactly one cycle.
- A sensor pulse shorter than DEBOUNCE synchronised cycles produces no event.
- No combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: CAPACITY=4, DEBOUNCE=2, GATE_CYCLES=5.
- Reset: assert `rst` for 2 cycles → `free_count`=4, `full`=0, `gate_open`=0, `deny`=0.
- Single entry: `entry_sensor` high for 10 cycles → `free_count` goes 4→3 at edge 5 and `gate_open` is high for exactly 5 cycles. The count does not drop again while the sensor stays high.
- Bounce rejection: `entry_sensor` high for 1 cycle, low, then high for 1 cycle → `free_count` stays 4 and `gate_open` stays 0.
- Fill and deny: four entries, each fully released, → `free_count`=0 and `full`=1. A fifth entry → `deny` is a single-cycle pulse, count stays 0, gate stays closed.
- Exit and underflow:
  - From `free_count`=4, an exit → count stays 4, no gate.
  - From 0, an exit → count 1, `full`=0, gate opens.
- Simultaneous and busy:
  - Entry and exit rising in the same cycle with `free_count`=2 → count stays 2 and the gate opens once.
  - An entry event during GATE → discarded, count unchanged.
  - `rst` asserted mid-GATE → `gate_open`=0 and count=4 on the next edge.

Source files
------------

// File: rtl/parking_slot_counter.sv
// Free-space counter for a parking lot: synchronised, debounced entry/exit sensors drive a
// gate-sequencing FSM that tracks free spaces, raises the barrier and flags refused entries.
module parking_slot_counter #(
    parameter int unsigned CAPACITY    = 4,
    parameter int unsigned DEBOUNCE    = 2,
    parameter int unsigned GATE_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    output logic [2:0] free_count,
    output logic       full,
    output logic       gate_open,
    output logic       deny
);

    localparam int unsigned DbW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int unsigned GcW = (GATE_CYCLES <= 1) ? 1 : $clog2(GATE_CYCLES);
    localparam logic [DbW-1:0] DbMax  = DbW'(DEBOUNCE);
    localparam logic [GcW-1:0] GcLast = GcW'(GATE_CYCLES - 1);
    localparam logic [2:0]     Cap    = 3'(CAPACITY);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGate = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    // Index 0 is the entry lane, index 1 the exit lane.
    logic [1:0]          meta_q, sync_q, deb_prev_q;
    logic [1:0][DbW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]          deb, ev;

    logic [1:0]     state_q, state_d;
    logic [2:0]     free_q, free_d;
    logic [GcW-1:0] gc_q, gc_d;
    logic           deny_q, deny_d;
    logic           entry_ok, exit_ok;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (!sync_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] >= DbMax) begin
                db_cnt_d[i] = db_cnt_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
            deb[i] = (db_cnt_q[i] >= DbMax);
            ev[i]  = deb[i] & ~deb_prev_q[i];
        end
    end

    // A simultaneous exit frees a space first, so a full lot can still admit the entry.
    assign exit_ok  = ev[1] && (free_q < Cap);
    assign entry_ok = ev[0] && ((free_q != 3'd0) || exit_ok);

    always_comb begin
        state_d = state_q;
        free_d  = free_q;
        gc_d    = gc_q;
        deny_d  = 1'b0;
        case (state_q)
            StIdle: begin
                gc_d   = '0;
                deny_d = ev[0] && !entry_ok;
                if (entry_ok || exit_ok) begin
                    state_d = StGate;
                end
                if (entry_ok && !exit_ok) begin
                    free_d = free_q - 3'd1;
                end else if (exit_ok && !entry_ok) begin
                    free_d = free_q + 3'd1;
                end
            end
            StGate: begin
                if (gc_q == GcLast) begin
                    state_d = StHold;
                end else begin
                    gc_d = gc_q + 1'b1;
                end
            end
            StHold: begin
                if (!deb[0] && !deb[1]) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            deb_prev_q <= '0;
            db_cnt_q   <= '0;
            state_q    <= StIdle;
            free_q     <= Cap;
            gc_q       <= '0;
            deny_q     <= 1'b0;
        end else begin
            meta_q     <= {exit_sensor, entry_sensor};
            sync_q     <= meta_q;
            deb_prev_q <= deb;
            db_cnt_q   <= db_cnt_d;
            state_q    <= state_d;
            free_q     <= free_d;
            gc_q       <= gc_d;
            deny_q     <= deny_d;
        end
    end

    assign free_count = free_q;
    assign full       = (free_q == 3'd0);
    assign gate_open  = (state_q == StGate);
    assign deny       = deny_q;

endmodule

// File: tb/tb_parking_slot_counter.sv
// Directed and randomized bench for parking_slot_counter against an edge-by-edge
// behavioural model built from sensor sample history and gate timing.
module tb_parking_slot_counter;

    localparam int unsigned CAP = 4;
    localparam int unsigned DEB = 2;
    localparam int unsigned GC  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic [2:0] free_count;
    logic       full, gate_open, deny;

    always #5 clk = ~clk;

    parking_slot_counter #(
        .CAPACITY   (CAP),
        .DEBOUNCE   (DEB),
        .GATE_CYCLES(GC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_sensor(entry_sensor),
        .exit_sensor (exit_sensor),
        .free_count  (free_count),
        .full        (full),
        .gate_open   (gate_open),
        .deny        (deny)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: raw sample history per lane (bit 0 = newest edge) and gate timing by edge index.
    int          t = 0;
    int          m_free = CAP;
    bit          m_busy = 1'b0;
    int          m_gate_end = 0;
    bit          m_deny = 1'b0;
    logic [15:0] he = '0, hx = '0;
    bit          de1 = 0, de2 = 0, dx1 = 0, dx2 = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    // A lane reads as asserted once the samples taken 2..DEB+1 edges ago were all high.
    function automatic bit deb_of(input logic [15:0] h);
        for (int k = 2; k <= DEB + 1; k++) begin
            if (!h[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge(input logic e, input logic x, input logic r);
        bit ev_e, ev_x, acc_e, acc_x;
        t++;
        if (r) begin
            m_free = CAP; m_busy = 0; m_deny = 0;
            he = '0; hx = '0; de1 = 0; de2 = 0; dx1 = 0; dx2 = 0;
            return;
        end
        ev_e   = de1 && !de2;
        ev_x   = dx1 && !dx2;
        m_deny = 0;
        if (!m_busy) begin
            if (ev_e && ev_x) begin
                acc_e = 1;
                acc_x = (m_free < CAP);
            end else begin
                acc_e = ev_e && (m_free > 0);
                acc_x = ev_x && (m_free < CAP);
            end
            m_free = m_free - int'(acc_e) + int'(acc_x);
            m_deny = ev_e && !acc_e;
            if (acc_e || acc_x) begin
                m_busy     = 1;
                m_gate_end = t + GC;
            end
        end else if (t > m_gate_end && !de1 && !dx1) begin
            m_busy = 0;
        end
        he  = {he[14:0], e};
        hx  = {hx[14:0], x};
        de2 = de1; de1 = deb_of(he);
        dx2 = dx1; dx1 = deb_of(hx);
    endtask

    task automatic step(input logic e, input logic x, input logic r);
        entry_sensor = e;
        exit_sensor  = x;
        rst          = r;
        @(posedge clk);
        model_edge(e, x, r);
        #1;
        check_val("free_count", 32'(free_count), 32'(m_free));
        check_val("full", 32'(full), 32'(m_free == 0));
        check_val("gate_open", 32'(gate_open), 32'(m_busy && (t < m_gate_end)));
        check_val("deny", 32'(deny), 32'(m_deny));
    endtask

    task automatic hold(input logic e, input logic x, input int n);
        for (int i = 0; i < n; i++) step(e, x, 1'b0);
    endtask

    initial begin
        step(0, 0, 1);
        step(0, 0, 1);
        // Spurious exit with an empty lot.
        hold(0, 1, 4);  hold(0, 0, 14);
        // Single long entry must count once.
        hold(1, 0, 10); hold(0, 0, 14);
        // Bounces shorter than the debounce window.
        hold(1, 0, 1);  hold(0, 0, 2);  hold(1, 0, 1);  hold(0, 0, 10);
        // Fill the lot, then refused entries.
        for (int i = 0; i < 5; i++) begin
            hold(1, 0, 4); hold(0, 0, 14);
        end
        // Exit from full, then another to reach two free spaces.
        hold(0, 1, 4);  hold(0, 0, 14);
        hold(0, 1, 4);  hold(0, 0, 14);
        // Simultaneous entry and exit.
        hold(1, 1, 4);  hold(0, 0, 14);
        // Entry arriving while the gate is busy.
        hold(1, 0, 4);  hold(0, 0, 2);  hold(1, 0, 4);  hold(0, 0, 14);
        // Reset while the gate is open.
        hold(1, 0, 6);  step(1, 0, 1);  hold(0, 0, 14);
        // Simultaneous events with a full lot.
        for (int i = 0; i < 4; i++) begin
            hold(1, 0, 4); hold(0, 0, 14);
        end
        hold(1, 1, 4);  hold(0, 0, 14);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                step(0, 0, 1);
            end else begin
                hold(1'($urandom % 2), 1'($urandom_range(0, 2) == 0), $urandom_range(1, 12));
            end
        end
        hold(0, 0, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
